pushbutton_debouncer: RTL

PUSHBUTTON_DEBOUNCER -- requirements
Module: pushbutton_debouncer

---
 rtl/pb_debounce_pkg.sv | 38 +++
 rtl/pb_debounce_chan.sv | 182 ++++++++++++++++++
 rtl/pushbutton_debouncer.sv | 52 +++++
 3 files changed

// File: rtl/pb_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_debounce_pkg
// Description : Shared types and constants for the pushbutton debouncer.
//               Holds the per-channel state enum, the default timing
//               constants (50 MHz clock), and a helper that sizes the
//               qualification/hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_debounce_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    REL   = 2'd0,  // stable released
    CHK_P = 2'd1,  // qualifying a press
    PRS   = 2'd2,  // stable pressed
    CHK_R = 2'd3   // qualifying a release
  } pb_state_t;

  // 10 ms and 1 s at 50 MHz.
  localparam int unsigned c_def_debounce_cycles = 500000;
  localparam int unsigned c_def_long_cycles     = 50000000;

  // The counter must hold LONG_CYCLES itself (saturation value) when long
  // press is enabled; otherwise only DEBOUNCE_CYCLES-1 is ever reached.
  function automatic int unsigned pb_cnt_width(
    input int unsigned debounce_cycles,
    input int unsigned long_cycles,
    input bit          long_en
  );
    int unsigned max_cnt;
    max_cnt = debounce_cycles;
    if (long_en && (long_cycles > max_cnt)) max_cnt = long_cycles;
    return $clog2(max_cnt + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pb_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : pb_debounce_chan
// Description : One debounced pushbutton channel: two-flop synchronizer,
//               four-state qualification FSM, shared counter, registered
//               press/release/long strobes.
//               Optional feature macro: PB_DEBOUNCE_LONGPRESS_EN enables the
//               long-press strobe; when undefined long_pulse is tied to 0.
// Ports       : clk           - rising-edge clock
//               reset_n       - asynchronous active-low reset
//               raw_in        - asynchronous pad level
//               db_out        - debounced level (same polarity as raw_in)
//               press_pulse   - one-cycle strobe per accepted press
//               release_pulse - one-cycle strobe per accepted release
//               long_pulse    - one-cycle strobe per long press
// Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce_chan
  import pb_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = c_def_debounce_cycles,
  parameter int unsigned LONG_CYCLES     = c_def_long_cycles,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic db_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

`ifdef PB_DEBOUNCE_LONGPRESS_EN
  localparam bit c_long_en = 1'b1;
`else
  localparam bit c_long_en = 1'b0;
`endif

  localparam int unsigned c_cnt_w = pb_cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, c_long_en);

  localparam logic c_pressed_lvl  = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic c_released_lvl = ~c_pressed_lvl;

  localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
`ifdef PB_DEBOUNCE_LONGPRESS_EN
  localparam logic [c_cnt_w-1:0] c_long_last = c_cnt_w'(LONG_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_long_sat  = c_cnt_w'(LONG_CYCLES);
`endif

  logic               r_sync1;
  logic               r_sync2;
  pb_state_t          r_state;
  pb_state_t          w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_db;
  logic               w_db_nxt;
  logic               r_press;
  logic               w_press_nxt;
  logic               r_release;
  logic               w_release_nxt;
  logic               w_pressed;

  // Metastability guard; nothing else looks at raw_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= c_released_lvl;
      r_sync2 <= c_released_lvl;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = (r_sync2 == c_pressed_lvl);

`ifdef PB_DEBOUNCE_LONGPRESS_EN
  logic r_long;
  logic w_long_nxt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= REL;
      r_cnt     <= '0;
      r_db      <= c_released_lvl;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_db      <= w_db_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

`ifdef PB_DEBOUNCE_LONGPRESS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_long <= 1'b0;
    else          r_long <= w_long_nxt;
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_db_nxt      = r_db;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
`ifdef PB_DEBOUNCE_LONGPRESS_EN
    w_long_nxt    = 1'b0;
`endif
    case (r_state)
      REL: begin
        if (w_pressed) begin
          w_state_nxt = CHK_P;
          w_cnt_nxt   = '0;
        end
      end
      CHK_P: begin
        if (!w_pressed) begin
          w_state_nxt = REL;
        end else if (r_cnt == c_db_last) begin
          w_state_nxt = PRS;
          w_db_nxt    = c_pressed_lvl;
          w_press_nxt = 1'b1;
          w_cnt_nxt   = '0;    // hold time starts at the accepted press
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRS: begin
        if (!w_pressed) begin
          w_state_nxt = CHK_R;
          w_cnt_nxt   = '0;
        end
`ifdef PB_DEBOUNCE_LONGPRESS_EN
        else if (r_cnt == c_long_last) begin
          w_long_nxt = 1'b1;
          w_cnt_nxt  = c_long_sat;
        end else if (r_cnt < c_long_last) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      CHK_R: begin
        if (w_pressed) begin
          w_state_nxt = PRS;
`ifdef PB_DEBOUNCE_LONGPRESS_EN
          // A release glitch ends this press's long-press window; parking
          // at saturation keeps a second long strobe from firing.
          w_cnt_nxt   = c_long_sat;
`endif
        end else if (r_cnt == c_db_last) begin
          w_state_nxt   = REL;
          w_db_nxt      = c_released_lvl;
          w_release_nxt = 1'b1;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = REL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign db_out        = r_db;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
`ifdef PB_DEBOUNCE_LONGPRESS_EN
  assign long_pulse    = r_long;
`else
  assign long_pulse    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pushbutton_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_debouncer
// Description : N_BUTTONS independent pushbutton debouncers. Each bit of
//               raw_in gets its own pb_debounce_chan instance; channels share
//               nothing but clock and reset.
//               Optional feature macro: PB_DEBOUNCE_LONGPRESS_EN (long-press
//               strobe); when undefined long_pulse is constant 0.
// Ports       : clk           - rising-edge clock
//               reset_n       - asynchronous active-low reset
//               raw_in        - [N_BUTTONS] asynchronous key pad levels
//               db_out        - [N_BUTTONS] debounced levels, raw_in polarity
//               press_pulse   - [N_BUTTONS] one-cycle accepted-press strobes
//               release_pulse - [N_BUTTONS] one-cycle accepted-release strobes
//               long_pulse    - [N_BUTTONS] one-cycle long-press strobes
// Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_debouncer
  import pb_debounce_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = c_def_debounce_cycles,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = c_def_long_cycles
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BUTTONS-1:0] raw_in,
  output logic [N_BUTTONS-1:0] db_out,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_pulse
);

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
    pb_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .raw_in        (raw_in[gi]),
      .db_out        (db_out[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .long_pulse    (long_pulse[gi])
    );
  end

endmodule
`default_nettype wire
